// File: rtl/regpair_sequencer.sv
// rtl/regpair_sequencer.sv - sequences 16-bit pair LOAD/INC/DEC/READ onto an 8-bit register file
// Optional feature macro: REGSEQ_WRAP_FLAG_EN adds the wrap output.
module regpair_sequencer #(
  parameter int PAIR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [PAIR_W-1:0]   cmd_pair,
  input  logic [2*DATA_W-1:0] cmd_imm,
  output logic [2:0]          rf_rd_sel,
  output logic                rf_rd_en,
  input  logic [DATA_W-1:0]   rf_rd_data,
  output logic [2:0]          rf_wr_sel,
  output logic                rf_wr_en,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                done,
  output logic                err,
  output logic [2*DATA_W-1:0] result
`ifdef REGSEQ_WRAP_FLAG_EN
  ,
  output logic                wrap
`endif
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam logic [2*DATA_W-1:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t                state;
  logic [1:0]            op_q;
  logic [PAIR_W-1:0]     pair_q;
  logic [DATA_W-1:0]     lo_q;
  logic [2*DATA_W-1:0]   val_q;
  logic [2*DATA_W-1:0]   rd_val;
  logic [2*DATA_W-1:0]   next_val;
  logic                  rd_en_q;
  logic                  wr_en_q;
`ifdef REGSEQ_WRAP_FLAG_EN
  logic                  wrap_q;
  logic                  wrap_det;
`endif

  function automatic logic [2:0] hi_sel(input logic [PAIR_W-1:0] p);
    return 3'({p, 1'b0});
  endfunction

  function automatic logic [2:0] lo_sel(input logic [PAIR_W-1:0] p);
    return 3'({p, 1'b1});
  endfunction

  // High byte is still on rf_rd_data during RD_HI, so the new value is formed before hi is stored.
  always_comb begin
    rd_val = {rf_rd_data, lo_q};
    case (op_q)
      OP_INC:  next_val = rd_val + ONE;
      OP_DEC:  next_val = rd_val - ONE;
      default: next_val = rd_val;
    endcase
`ifdef REGSEQ_WRAP_FLAG_EN
    wrap_det = ((op_q == OP_INC) && (rd_val == '1)) || ((op_q == OP_DEC) && (rd_val == '0));
`endif
  end

  // Reset kills the enables in the same cycle so an aborted command writes nothing further.
  assign rf_rd_en = rd_en_q & ~rst;
  assign rf_wr_en = wr_en_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rf_rd_sel  <= '0;
      rf_wr_sel  <= '0;
      rf_wr_data <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      op_q       <= OP_LOAD;
      pair_q     <= '0;
      lo_q       <= '0;
      val_q      <= '0;
`ifdef REGSEQ_WRAP_FLAG_EN
      wrap_q     <= 1'b0;
      wrap       <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
`ifdef REGSEQ_WRAP_FLAG_EN
      wrap    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            pair_q    <= cmd_pair;
            val_q     <= cmd_imm;
            cmd_ready <= 1'b0;
`ifdef REGSEQ_WRAP_FLAG_EN
            wrap_q    <= 1'b0;
`endif
            if (cmd_pair == '1) begin
              state  <= DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
            end else if (cmd_op == OP_LOAD) begin
              state      <= WR_LO;
              wr_en_q    <= 1'b1;
              rf_wr_sel  <= lo_sel(cmd_pair);
              rf_wr_data <= cmd_imm[DATA_W-1:0];
            end else begin
              state     <= RD_LO;
              rd_en_q   <= 1'b1;
              rf_rd_sel <= lo_sel(cmd_pair);
            end
          end
        end
        RD_LO: begin
          lo_q      <= rf_rd_data;
          state     <= RD_HI;
          rd_en_q   <= 1'b1;
          rf_rd_sel <= hi_sel(pair_q);
        end
        RD_HI: begin
          val_q <= next_val;
          if (op_q == OP_READ) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= rd_val;
          end else begin
            state      <= WR_LO;
            wr_en_q    <= 1'b1;
            rf_wr_sel  <= lo_sel(pair_q);
            rf_wr_data <= next_val[DATA_W-1:0];
`ifdef REGSEQ_WRAP_FLAG_EN
            wrap_q     <= wrap_det;
`endif
          end
        end
        WR_LO: begin
          state      <= WR_HI;
          wr_en_q    <= 1'b1;
          rf_wr_sel  <= hi_sel(pair_q);
          rf_wr_data <= val_q[2*DATA_W-1:DATA_W];
        end
        WR_HI: begin
          state  <= DONE;
          done   <= 1'b1;
          result <= val_q;
`ifdef REGSEQ_WRAP_FLAG_EN
          wrap   <= wrap_q;
`endif
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regpair_sequencer.sv
// tb/tb_regpair_sequencer.sv - self-checking bench for regpair_sequencer
// Vector table, corner-case sequences and a random run against a pair-level reference model.
module tb_regpair_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_pair;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_rd_sel;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data;
  logic [2:0]  rf_wr_sel;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic        wrap;

  regpair_sequencer #(.PAIR_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pair(cmd_pair), .cmd_imm(cmd_imm),
    .rf_rd_sel(rf_rd_sel), .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data),
    .rf_wr_sel(rf_wr_sel), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .done(done), .err(err), .result(result)
`ifdef REGSEQ_WRAP_FLAG_EN
    , .wrap(wrap)
`endif
  );

`ifndef REGSEQ_WRAP_FLAG_EN
  assign wrap = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: B C D E H L at 0..5
  logic [7:0] rf [0:7] = '{default: 8'h00};
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int both_cnt = 0;
  int done_cyc[$];

  assign rf_rd_data = rf[rf_rd_sel];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rf_wr_en) begin
      rf[rf_wr_sel] <= rf_wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (rf_rd_en && rf_wr_en) both_cnt = both_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] pair_val(input int p);
    return {rf[2*p], rf[2*p+1]};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] imm,
                         output logic [15:0] r, output logic e, output logic w, output int lat);
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_pair  = pair;
    cmd_imm   = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_pair  = 2'($urandom);
    cmd_imm   = 16'($urandom);
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    e = err;
    w = wrap;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  pair;
    logic [15:0] imm;
    logic [15:0] init;
    logic [15:0] exp_res;
    int          exp_lat;
    logic        exp_err;
    logic        exp_wrap;
  } vec_t;

  vec_t tbl[8];
  logic [15:0] m[0:2];

  initial begin
    logic [15:0] r;
    logic e;
    logic w;
    int lat;
    int w0;
    int d0;
    int n;

    tbl[0] = '{2'd0, 2'd2, 16'hC0DE, 16'h0000, 16'hC0DE, 3, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 2'd0, 16'h0000, 16'h12FF, 16'h1300, 5, 1'b0, 1'b0};
    tbl[2] = '{2'd2, 2'd1, 16'h0000, 16'h0000, 16'hFFFF, 5, 1'b0, 1'b1};
    tbl[3] = '{2'd0, 2'd3, 16'h1234, 16'h0000, 16'h0000, 1, 1'b1, 1'b0};
    tbl[4] = '{2'd1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 1, 1'b1, 1'b0};
    tbl[5] = '{2'd3, 2'd1, 16'h0000, 16'hBEEF, 16'hBEEF, 3, 1'b0, 1'b0};
    tbl[6] = '{2'd1, 2'd2, 16'h0000, 16'hFFFF, 16'h0000, 5, 1'b0, 1'b1};
    tbl[7] = '{2'd2, 2'd0, 16'h0000, 16'h0100, 16'h00FF, 5, 1'b0, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_pair = 2'd0;
    cmd_imm = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rd_en", 32'(rf_rd_en), 32'd0);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_rd_sel", 32'(rf_rd_sel), 32'd0);
    check("rst_wr_sel", 32'(rf_wr_sel), 32'd0);
    check("rst_wr_data", 32'(rf_wr_data), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;

    // LOAD HL=C0DE, cycle by cycle
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_pair = 2'd2; cmd_imm = 16'hC0DE;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("ld_t1_wr", 32'({rf_wr_en, rf_rd_en, rf_wr_sel, rf_wr_data}), 32'({1'b1, 1'b0, 3'd5, 8'hDE}));
    @(posedge clk); #1;
    check("ld_t2_wr", 32'({rf_wr_en, rf_rd_en, rf_wr_sel, rf_wr_data}), 32'({1'b1, 1'b0, 3'd4, 8'hC0}));
    @(posedge clk); #1;
    check("ld_t3_done", 32'({done, err, rf_wr_en, cmd_ready}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
    check("ld_t3_result", 32'(result), 32'hC0DE);
    check("ld_hl", 32'(pair_val(2)), 32'hC0DE);

    // INC BC 12FF, read/write select order
    run_cmd(2'd0, 2'd0, 16'h12FF, r, e, w, lat);
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_pair = 2'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("inc_t1_rd", 32'({rf_rd_en, rf_wr_en, rf_rd_sel}), 32'({1'b1, 1'b0, 3'd1}));
    @(posedge clk); #1;
    check("inc_t2_rd", 32'({rf_rd_en, rf_wr_en, rf_rd_sel}), 32'({1'b1, 1'b0, 3'd0}));
    @(posedge clk); #1;
    check("inc_t3_wr", 32'({rf_wr_en, rf_rd_en, rf_wr_sel, rf_wr_data}), 32'({1'b1, 1'b0, 3'd1, 8'h00}));
    @(posedge clk); #1;
    check("inc_t4_wr", 32'({rf_wr_en, rf_rd_en, rf_wr_sel, rf_wr_data}), 32'({1'b1, 1'b0, 3'd0, 8'h13}));
    @(posedge clk); #1;
    check("inc_t5_done", 32'({done, result}), 32'({1'b1, 16'h1300}));

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pair != 2'd3) run_cmd(2'd0, tbl[i].pair, tbl[i].init, r, e, w, lat);
      w0 = wr_cnt;
      run_cmd(tbl[i].op, tbl[i].pair, tbl[i].imm, r, e, w, lat);
      check($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].exp_res));
      check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
`ifdef REGSEQ_WRAP_FLAG_EN
      check($sformatf("tbl%0d_wrap", i), 32'(w), 32'(tbl[i].exp_wrap));
`endif
      if (tbl[i].pair == 2'd3) check($sformatf("tbl%0d_no_writes", i), 32'(wr_cnt - w0), 32'd0);
      else check($sformatf("tbl%0d_pair", i), 32'(pair_val(int'(tbl[i].pair))), 32'(tbl[i].exp_res));
    end

    // Reset during WR_HI of LOAD BC=AA55
    run_cmd(2'd0, 2'd0, 16'h0000, r, e, w, lat);
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_pair = 2'd0; cmd_imm = 16'hAA55;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_bc", 32'(pair_val(0)), 32'h0055);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Back-to-back READs with cmd_valid held high
    @(negedge clk);
    done_cyc.delete();
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_pair = 2'd0;
    n = 0;
    while (done_cyc.size() < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("b2b_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd4);
      check("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd4);
    end

    // Random run against the pair-level model
    for (int p = 0; p < 3; p++) begin
      m[p] = 16'($urandom);
      run_cmd(2'd0, 2'(p), m[p], r, e, w, lat);
    end
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [1:0]  pair;
      logic [15:0] imm;
      logic [15:0] cur;
      logic [15:0] xr;
      logic        xw;
      int          xl;
      int          sel;
      op   = 2'($urandom_range(0, 3));
      pair = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sel  = int'($urandom_range(0, 3));
      imm  = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'($urandom);
      xw = 1'b0;
      if (pair == 2'd3) begin
        xr = 16'h0000;
        xl = 1;
      end else begin
        cur = m[pair];
        case (op)
          2'd0: begin xr = imm; xl = 3; end
          2'd1: begin xr = cur + 16'd1; xl = 5; xw = (cur == 16'hFFFF); end
          2'd2: begin xr = cur - 16'd1; xl = 5; xw = (cur == 16'h0000); end
          default: begin xr = cur; xl = 3; end
        endcase
        m[pair] = xr;
      end
      w0 = wr_cnt;
      run_cmd(op, pair, imm, r, e, w, lat);
      check($sformatf("rnd%0d_result", i), 32'(r), 32'(xr));
      check($sformatf("rnd%0d_err", i), 32'(e), 32'(pair == 2'd3));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(xl));
`ifdef REGSEQ_WRAP_FLAG_EN
      check($sformatf("rnd%0d_wrap", i), 32'(w), 32'(xw));
`endif
      if (pair == 2'd3) check($sformatf("rnd%0d_no_writes", i), 32'(wr_cnt - w0), 32'd0);
      else check($sformatf("rnd%0d_pair", i), 32'(pair_val(int'(pair))), 32'(m[pair]));
    end

    check("rd_wr_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
